// File: rtl/sysio_bus_master.sv
// sysio_bus_master: single-outstanding register access master with read, write and atomic bit set/clear
module sysio_bus_master #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [1:0]    req_op_i,
  input  logic [AW-1:0] req_addr_i,
  input  logic [31:0]   req_data_i,
  input  logic [3:0]    req_sel_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [31:0]   rsp_data_o,
  output logic [AW-1:0] waddr_o,
  output logic [31:0]   data_o,
  output logic [3:0]    sel_o,
  output logic          we_o,
  output logic [AW-1:0] raddr_o,
  output logic          rd_o,
  input  logic [31:0]   data_i
);
  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_SET = 2'b10;
  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RSP} state_t;
  state_t      state;
  logic [1:0]  op;
  logic [31:0] mask;
  logic [31:0] rdata;
  assign rsp_data_o = rdata;
  // sequencer: every strobe and bus output is a flop so rd_o/we_o cannot glitch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_ready_o <= 1'b1;
      rd_o        <= 1'b0;
      we_o        <= 1'b0;
      rsp_valid_o <= 1'b0;
      waddr_o     <= '0;
      raddr_o     <= '0;
      data_o      <= '0;
      sel_o       <= '0;
      op          <= OP_RD;
      mask        <= '0;
      rdata       <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid_i) begin
          op          <= req_op_i;
          mask        <= req_data_i;
          waddr_o     <= req_addr_i;
          raddr_o     <= req_addr_i;
          req_ready_o <= 1'b0;
          if (req_op_i == OP_WR) begin
            state  <= WR;
            we_o   <= 1'b1;
            data_o <= req_data_i;
            sel_o  <= req_sel_i;
            rdata  <= '0;
          end else begin
            state <= RD;
            rd_o  <= 1'b1;
          end
        end
        RD: begin
          rd_o  <= 1'b0;
          state <= CAP;
        end
        CAP: begin
          rdata <= data_i;
          if (op == OP_RD) begin
            state       <= RSP;
            rsp_valid_o <= 1'b1;
          end else begin
            state  <= WR;
            we_o   <= 1'b1;
            sel_o  <= 4'hF;
            data_o <= (op == OP_SET) ? (data_i | mask) : (data_i & ~mask);
          end
        end
        WR: begin
          we_o        <= 1'b0;
          state       <= RSP;
          rsp_valid_o <= 1'b1;
        end
        RSP: if (rsp_ready_i) begin
          rsp_valid_o <= 1'b0;
          req_ready_o <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sysio_bus_master.sv
// tb_sysio_bus_master: randomized and directed checks against a transaction-level model
module tb_sysio_bus_master;
  localparam int AW = 8;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [1:0]    req_op_i = 2'b00;
  logic [AW-1:0] req_addr_i = '0;
  logic [31:0]   req_data_i = '0;
  logic [3:0]    req_sel_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b1;
  logic [31:0]   rsp_data_o;
  logic [AW-1:0] waddr_o;
  logic [31:0]   data_o;
  logic [3:0]    sel_o;
  logic          we_o;
  logic [AW-1:0] raddr_o;
  logic          rd_o;
  logic [31:0]   data_i = '0;

  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] salt = 32'h1234_5678;

  always #5 clk = ~clk;

  sysio_bus_master #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_sel_i(req_sel_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .waddr_o(waddr_o), .data_o(data_o), .sel_o(sel_o), .we_o(we_o),
    .raddr_o(raddr_o), .rd_o(rd_o), .data_i(data_i)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] seed(input logic [AW-1:0] a);
    return (a == 4) ? 32'h0000_00A5 : (({24'h0, a} * 32'h9E37_79B1) ^ salt);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] sel);
    logic [31:0] bm;
    bm = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    return (old & ~bm) | (d & bm);
  endfunction

  // peripheral responder: registered read data, byte-enabled writes over a seeded register file
  logic [31:0] resp_mem [256];
  bit          resp_wr  [256];
  always @(posedge clk) begin
    if (rd_o) data_i <= resp_wr[raddr_o] ? resp_mem[raddr_o] : seed(raddr_o);
    if (we_o) begin
      resp_mem[waddr_o] <= merge(resp_wr[waddr_o] ? resp_mem[waddr_o] : seed(waddr_o), data_o, sel_o);
      resp_wr[waddr_o]  <= 1'b1;
    end
  end

  // transaction model: what each accepted request must produce and when, counted in cycles since acceptance
  logic [31:0] ref_mem [256];
  bit          ref_wr  [256];
  bit          m_busy = 1'b0;
  int          m_t = 0;
  int          m_lat = 0;
  logic [1:0]  m_op = 2'b00;
  logic [AW-1:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_new = '0;
  logic [31:0] m_rsp = '0;
  logic [3:0]  m_wsel = '0;
  wire exp_rd = m_busy && m_op != 2'b01 && m_t == 1;
  wire exp_we = m_busy && ((m_op == 2'b01 && m_t == 1) || (m_op[1] && m_t == 3));
  wire exp_rv = m_busy && m_t >= m_lat;

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] old;
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_t    <= 0;
    end else if (!m_busy) begin
      if (req_valid_i) begin
        old     = ref_wr[req_addr_i] ? ref_mem[req_addr_i] : seed(req_addr_i);
        m_busy  <= 1'b1;
        m_t     <= 1;
        m_op    <= req_op_i;
        m_addr  <= req_addr_i;
        m_lat   <= (req_op_i == 2'b00) ? 3 : (req_op_i == 2'b01) ? 2 : 4;
        m_rsp   <= (req_op_i == 2'b01) ? 32'h0 : old;
        m_wsel  <= (req_op_i == 2'b01) ? req_sel_i : 4'hF;
        m_wdata <= (req_op_i == 2'b01) ? req_data_i : (req_op_i == 2'b10) ? (old | req_data_i) : (old & ~req_data_i);
        m_new   <= (req_op_i == 2'b01) ? merge(old, req_data_i, req_sel_i) : (req_op_i == 2'b10) ? (old | req_data_i) : (old & ~req_data_i);
      end
    end else begin
      if (exp_we) begin
        ref_mem[m_addr] <= m_new;
        ref_wr[m_addr]  <= 1'b1;
      end
      if (exp_rv && rsp_ready_i) m_busy <= 1'b0;
      else m_t <= m_t + 1;
    end
  end

  // per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("req_ready_o", {31'h0, req_ready_o}, {31'h0, !m_busy});
      chk("rd_o", {31'h0, rd_o}, {31'h0, exp_rd});
      chk("we_o", {31'h0, we_o}, {31'h0, exp_we});
      chk("rsp_valid_o", {31'h0, rsp_valid_o}, {31'h0, exp_rv});
      if (m_busy) begin
        chk("raddr_o", {24'h0, raddr_o}, {24'h0, m_addr});
        chk("waddr_o", {24'h0, waddr_o}, {24'h0, m_addr});
      end
      if (exp_we) begin
        chk("data_o", data_o, m_wdata);
        chk("sel_o", {28'h0, sel_o}, {28'h0, m_wsel});
      end
      if (exp_rv) chk("rsp_data_o", rsp_data_o, m_rsp);
    end
  end

  task automatic run_op(input logic [1:0] op, input logic [AW-1:0] addr, input logic [31:0] d,
                        input logic [3:0] sel, input int stall, output logic [31:0] rsp,
                        output int rd_at, output int we_at, output int rv_at,
                        output logic [31:0] wd, output logic [3:0] ws,
                        output logic [AW-1:0] ra, output logic [AW-1:0] wa);
    int nv;
    bit done;
    rsp = '0; wd = '0; ws = '0; ra = '0; wa = '0;
    rd_at = 0; we_at = 0; rv_at = 0; nv = 0; done = 1'b0;
    @(negedge clk);
    req_valid_i = 1'b1; req_op_i = op; req_addr_i = addr; req_data_i = d; req_sel_i = sel;
    rsp_ready_i = (stall == 0);
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    for (int k = 1; k <= 20 && !done; k++) begin
      @(negedge clk);
      if (rd_o && rd_at == 0) begin rd_at = k; ra = raddr_o; end
      if (we_o && we_at == 0) begin we_at = k; wd = data_o; ws = sel_o; wa = waddr_o; end
      if (rsp_valid_o) begin
        if (rv_at == 0) rv_at = k;
        nv++;
        rsp = rsp_data_o;
        if (nv > stall) begin rsp_ready_i = 1'b1; done = 1'b1; end
        else rsp_ready_i = 1'b0;
      end
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL rsp_timeout: got no response within 20 cycles, required one");
      rsp_ready_i = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] rsp, wd;
    logic [3:0] ws;
    logic [AW-1:0] ra, wa;
    int rd_at, we_at, rv_at, nwe, nrd, last;
    salt = $urandom;
    repeat (3) @(negedge clk);
    chk("rst_rd_o", {31'h0, rd_o}, 0);
    chk("rst_we_o", {31'h0, we_o}, 0);
    chk("rst_rsp_valid", {31'h0, rsp_valid_o}, 0);
    chk("rst_data_o", data_o, 0);
    chk("rst_sel_o", {28'h0, sel_o}, 0);
    chk("rst_waddr", {24'h0, waddr_o}, 0);
    chk("rst_raddr", {24'h0, raddr_o}, 0);
    chk("rst_rsp_data", rsp_data_o, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'h0, req_ready_o}, 1);

    run_op(2'b00, 8'h04, 32'h0, 4'h0, 0, rsp, rd_at, we_at, rv_at, wd, ws, ra, wa);
    chk("read_rd_at", rd_at, 1);
    chk("read_rv_at", rv_at, 3);
    chk("read_no_we", we_at, 0);
    chk("read_raddr", {24'h0, ra}, 32'h04);
    chk("read_data", rsp, 32'h0000_00A5);

    run_op(2'b01, 8'h08, 32'hFFFF_0000, 4'b1100, 0, rsp, rd_at, we_at, rv_at, wd, ws, ra, wa);
    chk("write_we_at", we_at, 1);
    chk("write_rv_at", rv_at, 2);
    chk("write_no_rd", rd_at, 0);
    chk("write_waddr", {24'h0, wa}, 32'h08);
    chk("write_data", wd, 32'hFFFF_0000);
    chk("write_sel", {28'h0, ws}, 32'hC);
    chk("write_rsp", rsp, 32'h0);

    run_op(2'b10, 8'h04, 32'h0000_0100, 4'b0001, 0, rsp, rd_at, we_at, rv_at, wd, ws, ra, wa);
    chk("set_rd_at", rd_at, 1);
    chk("set_we_at", we_at, 3);
    chk("set_rv_at", rv_at, 4);
    chk("set_data", wd, 32'h0000_01A5);
    chk("set_sel", {28'h0, ws}, 32'hF);
    chk("set_rsp", rsp, 32'h0000_00A5);

    run_op(2'b11, 8'h04, 32'h0000_0005, 4'h0, 5, rsp, rd_at, we_at, rv_at, wd, ws, ra, wa);
    chk("clr_data", wd, 32'h0000_01A0);
    chk("clr_rsp", rsp, 32'h0000_01A5);
    chk("clr_rv_at", rv_at, 4);

    run_op(2'b00, 8'h04, 32'h0, 4'h0, 0, rsp, rd_at, we_at, rv_at, wd, ws, ra, wa);
    chk("reread_data", rsp, 32'h0000_01A0);

    @(negedge clk);
    req_valid_i = 1'b1; req_op_i = 2'b10; req_addr_i = 8'h04; req_data_i = 32'h0000_F000;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_rd_o", {31'h0, rd_o}, 0);
    chk("abort_we_o", {31'h0, we_o}, 0);
    chk("abort_rsp_valid", {31'h0, rsp_valid_o}, 0);
    chk("abort_req_ready", {31'h0, req_ready_o}, 1);
    chk("abort_data_o", data_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nwe = 0;
    repeat (10) begin
      @(negedge clk);
      if (we_o) nwe++;
    end
    chk("abort_no_we", nwe, 0);
    run_op(2'b00, 8'h04, 32'h0, 4'h0, 0, rsp, rd_at, we_at, rv_at, wd, ws, ra, wa);
    chk("abort_data_kept", rsp, 32'h0000_01A0);

    @(negedge clk);
    req_valid_i = 1'b1; req_op_i = 2'b00; rsp_ready_i = 1'b1;
    req_addr_i = 8'($urandom_range(0, 15));
    nrd = 0; last = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rd_o) begin
        nrd++;
        if (last != 0) chk("b2b_rd_gap", k - last, 4);
        last = k;
      end
      req_addr_i = 8'($urandom_range(0, 15));
    end
    chk("b2b_rd_count", nrd, 10);
    req_valid_i = 1'b0;
    repeat (6) @(negedge clk);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      req_valid_i = ($urandom_range(0, 2) != 0);
      req_op_i    = 2'($urandom_range(0, 3));
      req_addr_i  = 8'($urandom_range(0, 15));
      req_data_i  = $urandom;
      req_sel_i   = 4'($urandom_range(0, 15));
      rsp_ready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 399) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    repeat (10) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
